// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: instruction classes, ALU op codes,
// FSM states and instruction field layout.
// No ports; imported by the interface, the register file and the top.
package alu_sequencer_pkg;

   localparam int DATA_W  = 8;
   localparam int INSTR_W = 16;
   localparam int NREGS   = 4;
   localparam int REG_AW  = 2;

   // Instruction classes, bits [15:14]
   typedef enum logic [1:0] {
      CLS_ALU  = 2'b00,
      CLS_LDI  = 2'b01,
      CLS_JZ   = 2'b10,
      CLS_HALT = 2'b11
   } cls_e;

   // ALU operation codes as understood by the external ALU
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_DIV = 3'd6;
   localparam logic [2:0] OP_EQ  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DECODE = 2'd2,
      ST_EXEC   = 2'd3
   } state_e;

   // Field positions; imm [7:0] overlaps rs1/rs2, only one view is used per class
   localparam int CLS_LSB = 14;
   localparam int OP_LSB  = 11;
   localparam int RD_LSB  = 9;
   localparam int RS1_LSB = 7;
   localparam int RS2_LSB = 5;
   localparam int IMM_W   = 8;

   // Register-field view of an instruction word
   typedef struct packed {
      cls_e             cls;
      logic [2:0]       op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [4:0]       tail;
   } instr_t;

   // Only what EXEC still needs once the word has been decoded
   typedef struct packed {
      logic [2:0]        op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
   } ir_t;

   function automatic logic [IMM_W-1:0] imm_of(input logic [INSTR_W-1:0] w);
      return w[IMM_W-1:0];
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of all non-clock signals between the sequencer and its environment
// (control, program ROM port, ALU port, flags, debug read).
// master = sequencer side, slave = ROM/ALU/controller side.
interface alu_sequencer_if #(parameter int PC_W = 8);
   import alu_sequencer_pkg::*;

   logic                 start;
   logic [PC_W-1:0]      start_addr;
   logic                 busy;
   logic                 done;
   logic                 imem_en;
   logic [PC_W-1:0]      imem_addr;
   logic [INSTR_W-1:0]   imem_data;
   logic [2:0]           alu_sel;
   logic [DATA_W-1:0]    alu_a;
   logic [DATA_W-1:0]    alu_b;
   logic [DATA_W-1:0]    alu_out;
   logic                 alu_carry;
   logic                 zero_flag;
   logic                 carry_flag;
   logic [REG_AW-1:0]    dbg_sel;
   logic [DATA_W-1:0]    dbg_data;

   modport master (
      input  start, start_addr, imem_data, alu_out, alu_carry, dbg_sel,
      output busy, done, imem_en, imem_addr, alu_sel, alu_a, alu_b,
             zero_flag, carry_flag, dbg_data
   );

   modport slave (
      output start, start_addr, imem_data, alu_out, alu_carry, dbg_sel,
      input  busy, done, imem_en, imem_addr, alu_sel, alu_a, alu_b,
             zero_flag, carry_flag, dbg_data
   );

endinterface

// File: rtl/alu_sequencer_regfile.sv
// 4x8 register file: two async read ports, one async debug read, one sync write.
// Ports: clk, rst (async active-high), we_i/wa_i/wd_i write, ra1_i/ra2_i/rdbg_i
// read addresses, rd1_o/rd2_o/rdbg_o read data. Reads see the old value on a write edge.
module seq_regfile
   import alu_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [REG_AW-1:0] wa_i,
   input  logic [DATA_W-1:0] wd_i,
   input  logic [REG_AW-1:0] ra1_i,
   input  logic [REG_AW-1:0] ra2_i,
   input  logic [REG_AW-1:0] rdbg_i,
   output logic [DATA_W-1:0] rd1_o,
   output logic [DATA_W-1:0] rd2_o,
   output logic [DATA_W-1:0] rdbg_o
);

   logic [DATA_W-1:0] regs_q [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign rd1_o  = regs_q[ra1_i];
   assign rd2_o  = regs_q[ra2_i];
   assign rdbg_o = regs_q[rdbg_i];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer driving a shared combinational 8-bit ALU.
// Latency: LDI/JZ 2 cycles, ALU ops 3 cycles, HALT 2 cycles then a done pulse.
// No backpressure: ROM answers one cycle after imem_en, ALU is combinational.
// Ports: clk, rst (async active-high), bus_if (master modport of alu_sequencer_if).
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   alu_sequencer_if.master bus_if
);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   ir_t               ir_q, ir_d;
   logic              zero_q, zero_d;
   logic              carry_q, carry_d;
   logic              done_q, done_d;

   logic              rf_we;
   logic [REG_AW-1:0] rf_wa;
   logic [DATA_W-1:0] rf_wd;
   logic [DATA_W-1:0] rf_rd1, rf_rd2;

   // The ROM word is only valid during DECODE; it is interpreted directly
   // there and only the ALU fields are kept for EXEC.
   instr_t            dec;
   logic [IMM_W-1:0]  dec_imm;

   assign dec     = instr_t'(bus_if.imem_data);
   assign dec_imm = imm_of(bus_if.imem_data);

   seq_regfile u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we_i   (rf_we),
      .wa_i   (rf_wa),
      .wd_i   (rf_wd),
      .ra1_i  (ir_q.rs1),
      .ra2_i  (ir_q.rs2),
      .rdbg_i (bus_if.dbg_sel),
      .rd1_o  (rf_rd1),
      .rd2_o  (rf_rd2),
      .rdbg_o (bus_if.dbg_data)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus_if.start) state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            case (dec.cls)
               CLS_ALU:  state_d = ST_EXEC;
               CLS_HALT: state_d = ST_IDLE;
               default:  state_d = ST_FETCH;
            endcase
         end
         ST_EXEC:   state_d = ST_FETCH;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output / datapath-control logic
   always_comb begin
      bus_if.imem_en = 1'b0;
      rf_we          = 1'b0;
      rf_wa          = ir_q.rd;
      rf_wd          = bus_if.alu_out;
      pc_d           = pc_q;
      ir_d           = ir_q;
      zero_d         = zero_q;
      carry_d        = carry_q;
      done_d         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus_if.start) pc_d = bus_if.start_addr;
         end
         ST_FETCH: begin
            bus_if.imem_en = 1'b1;
         end
         ST_DECODE: begin
            ir_d = '{op: dec.op, rd: dec.rd, rs1: dec.rs1, rs2: dec.rs2};
            pc_d = pc_q + PC_W'(1);
            case (dec.cls)
               CLS_LDI: begin
                  rf_we = 1'b1;
                  rf_wa = dec.rd;
                  rf_wd = dec_imm;
               end
               // A taken branch replaces the incremented pc
               CLS_JZ:   if (zero_q) pc_d = PC_W'(dec_imm);
               CLS_HALT: done_d = 1'b1;
               default: ;
            endcase
         end
         ST_EXEC: begin
            rf_we   = 1'b1;
            zero_d  = (bus_if.alu_out == '0);
            carry_d = bus_if.alu_carry;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= '0;
         ir_q    <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         done_q  <= done_d;
      end
   end

   assign bus_if.busy       = (state_q != ST_IDLE);
   assign bus_if.done       = done_q;
   assign bus_if.imem_addr  = pc_q;
   // Operands come from ir at all times so the ALU inputs stay stable
   assign bus_if.alu_sel    = ir_q.op;
   assign bus_if.alu_a      = rf_rd1;
   assign bus_if.alu_b      = rf_rd2;
   assign bus_if.zero_flag  = zero_q;
   assign bus_if.carry_flag = carry_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ROM and ALU.
module tb_alu_sequencer;

   logic clk;
   logic rst;

   alu_sequencer_if #(.PC_W(8)) bus ();

   alu_sequencer #(.PC_W(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program ROM, one-cycle read latency
   logic [15:0] rom [256];
   always @(posedge clk) begin
      if (bus.imem_en) bus.imem_data <= rom[bus.imem_addr];
   end

   // Reference ALU
   logic [8:0]  alu_t9;
   logic [15:0] alu_p;
   always_comb begin
      alu_t9        = '0;
      alu_p         = '0;
      bus.alu_out   = '0;
      bus.alu_carry = 1'b0;
      case (bus.alu_sel)
         3'd0: begin
            alu_t9        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            bus.alu_out   = alu_t9[7:0];
            bus.alu_carry = alu_t9[8];
         end
         3'd1: begin
            bus.alu_out   = bus.alu_a - bus.alu_b;
            bus.alu_carry = (bus.alu_a < bus.alu_b);
         end
         3'd2: bus.alu_out = bus.alu_a & bus.alu_b;
         3'd3: bus.alu_out = bus.alu_a | bus.alu_b;
         3'd4: bus.alu_out = bus.alu_a ^ bus.alu_b;
         3'd5: begin
            alu_p         = bus.alu_a * bus.alu_b;
            bus.alu_out   = alu_p[7:0];
            bus.alu_carry = |alu_p[15:8];
         end
         3'd6: begin
            if (bus.alu_b == 8'd0) begin
               bus.alu_out   = 8'd0;
               bus.alu_carry = 1'b1;
            end else begin
               bus.alu_out   = bus.alu_a / bus.alu_b;
            end
         end
         default: bus.alu_out = {7'd0, bus.alu_a == bus.alu_b};
      endcase
   end

   int n_cmp;
   int n_bad;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] i_ldi(input logic [1:0] rd, input logic [7:0] imm);
      return {2'b01, 3'b000, rd, 1'b0, imm};
   endfunction

   function automatic logic [15:0] i_alu(input logic [2:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2);
      return {2'b00, op, rd, rs1, rs2, 5'b00000};
   endfunction

   function automatic logic [15:0] i_jz(input logic [7:0] tgt);
      return {2'b10, 6'b000000, tgt};
   endfunction

   localparam logic [15:0] I_HALT = 16'hC000;

   task automatic rom_clear();
      for (int i = 0; i < 256; i++) rom[i] = I_HALT;
   endtask

   task automatic check_reg(input string tag, input logic [1:0] r, input logic [7:0] exp);
      bus.dbg_sel = r;
      #1;
      check_eq(tag, {24'd0, bus.dbg_data}, {24'd0, exp});
   endtask

   // Called at a negedge; pulses start for one cycle and waits for done.
   task automatic run_prog(input string tag, input logic [7:0] addr);
      bool_wait: begin
         bus.start      = 1'b1;
         bus.start_addr = addr;
         @(negedge clk);
         bus.start = 1'b0;
         for (int i = 0; i < 300; i++) begin
            if (bus.done) disable bool_wait;
            @(negedge clk);
         end
         check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      end
      @(negedge clk);
   endtask

   logic [11:0] busy_v, done_v;

   initial begin
      n_cmp          = 0;
      n_bad          = 0;
      bus.start      = 1'b0;
      bus.start_addr = '0;
      bus.dbg_sel    = '0;
      bus.imem_data  = '0;
      rom_clear();
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check_eq("rst_busy",  {31'd0, bus.busy},       32'd0);
      check_eq("rst_done",  {31'd0, bus.done},       32'd0);
      check_eq("rst_imem_en", {31'd0, bus.imem_en},  32'd0);
      check_eq("rst_pc",    {24'd0, bus.imem_addr},  32'd0);
      check_eq("rst_zero",  {31'd0, bus.zero_flag},  32'd0);
      check_eq("rst_carry", {31'd0, bus.carry_flag}, 32'd0);
      check_reg("rst_r0", 2'd0, 8'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic program with cycle-exact busy/done trace
      rom[0] = i_ldi(2'd0, 8'd5);
      rom[1] = i_ldi(2'd1, 8'd3);
      rom[2] = i_alu(3'd0, 2'd2, 2'd0, 2'd1);
      rom[3] = I_HALT;
      bus.start      = 1'b1;
      bus.start_addr = 8'h00;
      busy_v = '0;
      done_v = '0;
      for (int c = 0; c < 12; c++) begin
         busy_v[c] = bus.busy;
         done_v[c] = bus.done;
         @(negedge clk);
         bus.start = 1'b0;
      end
      check_eq("t2_busy_trace", {20'd0, busy_v}, {20'd0, 12'h3FE});
      check_eq("t2_done_trace", {20'd0, done_v}, {20'd0, 12'h400});
      check_reg("t2_r2", 2'd2, 8'd8);

      // ADD with carry out, then SUB with borrow
      rom_clear();
      rom[0] = i_ldi(2'd0, 8'd200);
      rom[1] = i_ldi(2'd1, 8'd100);
      rom[2] = i_alu(3'd0, 2'd2, 2'd0, 2'd1);
      rom[3] = I_HALT;
      rom[8] = i_alu(3'd1, 2'd3, 2'd1, 2'd0);
      rom[9] = I_HALT;
      run_prog("t3a", 8'h00);
      check_reg("t3_add_r2", 2'd2, 8'd44);
      check_eq("t3_add_carry", {31'd0, bus.carry_flag}, 32'd1);
      check_eq("t3_add_zero",  {31'd0, bus.zero_flag},  32'd0);
      run_prog("t3b", 8'h08);
      check_reg("t3_sub_r3", 2'd3, 8'd156);
      check_eq("t3_sub_carry", {31'd0, bus.carry_flag}, 32'd1);

      // Divide by zero, then taken JZ
      rom_clear();
      rom[8'h30] = i_ldi(2'd1, 8'd0);
      rom[8'h31] = i_alu(3'd6, 2'd2, 2'd0, 2'd1);
      rom[8'h32] = i_jz(8'h20);
      rom[8'h33] = i_ldi(2'd3, 8'h11);
      rom[8'h34] = I_HALT;
      rom[8'h20] = i_ldi(2'd3, 8'h77);
      rom[8'h21] = I_HALT;
      run_prog("t4", 8'h30);
      check_reg("t4_div_r2", 2'd2, 8'd0);
      check_eq("t4_div_zero",  {31'd0, bus.zero_flag},  32'd1);
      check_eq("t4_div_carry", {31'd0, bus.carry_flag}, 32'd1);
      check_reg("t4_jz_taken_r3", 2'd3, 8'h77);
      check_eq("t4_pc_after", {24'd0, bus.imem_addr}, 32'h22);

      // Logic ops; rd equal to rs1 read-before-write
      rom_clear();
      rom[8'h50] = i_ldi(2'd0, 8'h0F);
      rom[8'h51] = i_ldi(2'd1, 8'h3C);
      rom[8'h52] = i_alu(3'd4, 2'd2, 2'd0, 2'd1);
      rom[8'h53] = i_alu(3'd2, 2'd3, 2'd0, 2'd1);
      rom[8'h54] = i_alu(3'd3, 2'd1, 2'd1, 2'd0);
      rom[8'h55] = I_HALT;
      run_prog("tl", 8'h50);
      check_reg("tl_xor_r2", 2'd2, 8'h33);
      check_reg("tl_and_r3", 2'd3, 8'h0C);
      check_reg("tl_or_r1",  2'd1, 8'h3F);
      check_eq("tl_carry", {31'd0, bus.carry_flag}, 32'd0);

      // JZ not taken falls through
      rom_clear();
      rom[0] = i_ldi(2'd0, 8'd1);
      rom[1] = i_ldi(2'd1, 8'd1);
      rom[2] = i_alu(3'd0, 2'd2, 2'd0, 2'd1);
      rom[3] = i_jz(8'h40);
      rom[4] = i_ldi(2'd3, 8'h55);
      rom[5] = I_HALT;
      rom[8'h40] = i_ldi(2'd3, 8'hAA);
      rom[8'h41] = I_HALT;
      run_prog("t5", 8'h00);
      check_reg("t5_fallthru_r3", 2'd3, 8'h55);
      check_eq("t5_pc_after", {24'd0, bus.imem_addr}, 32'h06);

      // pc wraps from 0xFF to 0x00
      rom_clear();
      rom[8'hFF] = i_ldi(2'd0, 8'h5A);
      rom[8'h00] = I_HALT;
      run_prog("t5w", 8'hFF);
      check_reg("t5_wrap_r0", 2'd0, 8'h5A);
      check_eq("t5_wrap_pc", {24'd0, bus.imem_addr}, 32'h01);

      // start while busy is ignored
      rom_clear();
      rom[8'h10] = i_ldi(2'd0, 8'd1);
      rom[8'h11] = i_ldi(2'd1, 8'd2);
      rom[8'h12] = i_ldi(2'd2, 8'd3);
      rom[8'h13] = I_HALT;
      rom[8'h80] = i_ldi(2'd3, 8'hEE);
      rom[8'h81] = I_HALT;
      bus.start      = 1'b1;
      bus.start_addr = 8'h10;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.start_addr = 8'h80;
      @(negedge clk);
      bus.start = 1'b0;
      check_eq("t6_pc_during", {24'd0, bus.imem_addr}, 32'h11);
      run_wait: begin
         for (int i = 0; i < 100; i++) begin
            if (bus.done) disable run_wait;
            @(negedge clk);
         end
         check_eq("t6_timeout", 32'd0, 32'd1);
      end
      @(negedge clk);
      check_reg("t6_r2", 2'd2, 8'd3);
      check_reg("t6_r3_untouched", 2'd3, 8'h55);
      check_eq("t6_pc_after", {24'd0, bus.imem_addr}, 32'h14);

      // Reset during EXEC: no writeback, everything cleared
      rom_clear();
      rom[0] = i_ldi(2'd0, 8'd9);
      rom[1] = i_ldi(2'd1, 8'd9);
      rom[2] = i_alu(3'd0, 2'd3, 2'd0, 2'd1);
      rom[3] = I_HALT;
      bus.start      = 1'b1;
      bus.start_addr = 8'h00;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
      // Now in EXEC of the ADD (cycle 7)
      check_eq("t1_in_exec_busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      #1;
      check_eq("t1_busy",  {31'd0, bus.busy},       32'd0);
      check_eq("t1_done",  {31'd0, bus.done},       32'd0);
      check_eq("t1_pc",    {24'd0, bus.imem_addr},  32'd0);
      check_eq("t1_zero",  {31'd0, bus.zero_flag},  32'd0);
      check_eq("t1_carry", {31'd0, bus.carry_flag}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("t1_idle_after", {31'd0, bus.busy}, 32'd0);
      check_reg("t1_r0", 2'd0, 8'd0);
      check_reg("t1_r1", 2'd1, 8'd0);
      check_reg("t1_r2", 2'd2, 8'd0);
      check_reg("t1_r3_unwritten", 2'd3, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
